// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among NumReq producers,
// feeding a one-entry commit stage that drives the write port and answers pending-write queries.
module regfile_write_arbiter #(
  parameter int DataWidth  = 16,
  parameter int NumRegs    = 8,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int NumReq     = 3
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [NumReq-1:0]                reqValid,
  output logic [NumReq-1:0]                reqReady,
  input  logic [NumReq*IndexWidth-1:0]     reqAddr,
  input  logic [NumReq*DataWidth-1:0]      reqData,
  input  logic                             rfStall,
  output logic                             rfWriteEn,
  output logic [IndexWidth-1:0]            rfWriteAddr,
  output logic [DataWidth-1:0]             rfWriteData,
  output logic [$clog2(NumReq)-1:0]        grantId,
  input  logic [IndexWidth-1:0]            queryAddr,
  output logic                             queryPending
);

  localparam int GrantWidth = $clog2(NumReq);
  localparam logic [GrantWidth-1:0] LastReq = GrantWidth'(NumReq - 1);
  localparam logic [GrantWidth:0]   ReqCount = (GrantWidth + 1)'(NumReq);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  stage_state_t state;
  stage_state_t next_state;

  logic [IndexWidth-1:0] stage_addr;
  logic [DataWidth-1:0]  stage_data;
  logic [GrantWidth-1:0] stage_src;
  logic [GrantWidth-1:0] rr_ptr;

  logic                  stage_full;
  logic                  commit;
  logic                  can_accept;
  logic                  accept;
  logic                  win_found;
  logic [GrantWidth-1:0] winner;
  logic [GrantWidth:0]   cand;

  always_comb begin
    stage_full = (state == FULL);
    commit     = stage_full & ~rfStall;
    can_accept = ~stage_full | commit;
  end

  // Scan from rr_ptr upward with wraparound; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr} + (GrantWidth + 1)'(k);
      if (cand >= ReqCount) begin
        cand = cand - ReqCount;
      end
      if (!win_found && reqValid[cand[GrantWidth-1:0]]) begin
        win_found = 1'b1;
        winner    = cand[GrantWidth-1:0];
      end
    end
  end

  always_comb begin
    accept   = can_accept & win_found;
    reqReady = '0;
    if (rstN && accept) begin
      reqReady[winner] = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (accept) begin
      next_state = FULL;
    end else if (commit) begin
      next_state = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Stage contents only change on accept, so they stay frozen while the register file stalls.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      stage_addr <= '0;
      stage_data <= '0;
      stage_src  <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      stage_addr <= reqAddr[int'(winner)*IndexWidth +: IndexWidth];
      stage_data <= reqData[int'(winner)*DataWidth +: DataWidth];
      stage_src  <= winner;
      rr_ptr     <= (winner == LastReq) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    rfWriteEn    = rstN & commit;
    rfWriteAddr  = stage_addr;
    rfWriteData  = stage_data;
    grantId      = stage_src;
    queryPending = rstN & stage_full & (stage_addr == queryAddr);
  end

endmodule
